user_register_bank: RTL and testbench
=====================================

// Module: user_register_bank
// PURPOSE
//   Parametrised bank of NUM_REGS general registers, each WIDTH bits, with
//   load/increment/decrement/clear on one selected register per cycle.
//   Generalises the CPU's single 12-bit user register: adds selectable step,
//   wrap or saturate arithmetic, a sticky overflow flag, bank-wide clear and
//   two combinational read ports. Serves as the CPU's pointer/counter bank.
// PARAMETERS
//   WIDTH     12  register width in bits (>=2)
//   NUM_REGS  4   number of registers (>=2)
//   AW        $clog2(NUM_REGS)  address width (derived, not overridden)
//   STEP      1   INC/DEC amount; 1 <= STEP < 2**WIDTH
//   SAT_MODE  0   0 = modulo-2**WIDTH wrap, 1 = saturate at 0 / 2**WIDTH-1
//   RESET_VAL 0   value loaded into every register by reset, CLR and CLR_ALL
// PORTS
//   CLK      in   1      clock; all state updates on the falling edge
//   RST_N    in   1      asynchronous reset, active low
//   WADDR    in   AW     register targeted by LOAD/INC/DEC/CLR
//   inpData  in   WIDTH  LOAD data
//   LOAD     in   1      load inpData into reg[WADDR]
//   INC      in   1      reg[WADDR] += STEP
//   DEC      in   1      reg[WADDR] -= STEP
//   CLR      in   1      reg[WADDR] <= RESET_VAL
//   CLR_ALL  in   1      every register <= RESET_VAL
//   OVF_CLR  in   1      clear sticky OVF
//   RADDR_A  in   AW     read port A address
//   RADDR_B  in   AW     read port B address
//   opDataA  out  WIDTH  reg[RADDR_A], combinational
//   opDataB  out  WIDTH  reg[RADDR_B], combinational
//   ZERO_A   out  1      1 when opDataA == 0
//   OVF      out  1      sticky overflow/underflow flag
// BEHAVIOUR
//   - RST_N low: all registers = RESET_VAL, OVF = 0, immediately, no CLK edge
//     needed; holds until RST_N high. Reset mid-operation discards pending op.
//   - Writes occur on negedge CLK. Read ports are combinational and reflect
//     the state after the most recent falling edge (zero read latency).
//   - Per-edge priority: CLR_ALL > CLR > LOAD > INC > DEC > hold.
//     Only the highest asserted op acts; at most one register changes,
//     except under CLR_ALL.
//   - WADDR >= NUM_REGS: CLR/LOAD/INC/DEC are ignored and no flag changes.
//     RADDR_x >= NUM_REGS reads 0.
//   - Arithmetic is computed in WIDTH+1 bits.
//     INC: if reg + STEP > 2**WIDTH-1, overflow.
//     DEC: if reg < STEP, underflow.
//   - Overflow/underflow with SAT_MODE=0: result = (reg +/- STEP) mod 2**WIDTH.
//     With SAT_MODE=1: result = 2**WIDTH-1 (INC) or 0 (DEC).
//     Either mode sets OVF = 1 on that edge.
//   - OVF: set by any over/underflow; cleared only by OVF_CLR or reset.
//     Set and OVF_CLR on the same edge: set wins.
//     CLR, CLR_ALL and LOAD do not affect OVF.
//   - A saturated register that is incremented again stays at max and sets OVF.
// TESTING  (WIDTH=12, NUM_REGS=4, STEP=1, SAT_MODE=0 unless stated)
//   1 LOAD WADDR=2 inpData=0xABC, RADDR_A=2, RADDR_B=0 -> opDataA=0xABC,
//     opDataB=0x000, ZERO_A=0.
//   2 LOAD r1=0xFFF, then INC WADDR=1, RADDR_A=1 -> opDataA=0x000, ZERO_A=1,
//     OVF=1. Then DEC r1 -> 0xFFF, OVF stays 1. OVF_CLR -> OVF=0.
//   3 SAT_MODE=1, STEP=4: r0=0xFFE, INC -> 0xFFF, OVF=1.
//     Then r0=0x002, DEC -> 0x000. r0=0x008, DEC -> 0x004, OVF unchanged.
//   4 Same edge CLR+LOAD+INC on r3 -> 0x000; LOAD(0x123)+INC -> 0x123;
//     INC+DEC -> +1; overflow and OVF_CLR together -> OVF=1.
//   5 NUM_REGS=3: WADDR=3 with LOAD 0x555 -> no register changes.
//     Then CLR_ALL with OVF=1 -> all registers 0, OVF still 1.
//   6 Registers loaded to nonzero, RST_N pulsed low between edges ->
//     outputs 0 and OVF 0 before the next negedge. Normal ops resume on the
//     first negedge after RST_N rises.

Source files
------------

// File: rtl/user_register_bank.sv
// Bank of NUM_REGS counters/pointers updated on the falling clock edge,
// with wrap or saturate arithmetic, a sticky overflow flag and two read ports.
module user_register_bank #(
  parameter int                 WIDTH     = 12,
  parameter int                 NUM_REGS  = 4,
  parameter int                 STEP      = 1,
  parameter int                 SAT_MODE  = 0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                AW        = $clog2(NUM_REGS)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] inpData,
  input  logic             LOAD,
  input  logic             INC,
  input  logic             DEC,
  input  logic             CLR,
  input  logic             CLR_ALL,
  input  logic             OVF_CLR,
  input  logic [AW-1:0]    RADDR_A,
  input  logic [AW-1:0]    RADDR_B,
  output logic [WIDTH-1:0] opDataA,
  output logic [WIDTH-1:0] opDataB,
  output logic             ZERO_A,
  output logic             OVF
);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_ovf;

  logic             w_addrValid;
  logic [AW-1:0]    w_idx;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next;
  logic             w_write;
  logic             w_setOvf;

  assign w_addrValid = int'(WADDR) < NUM_REGS;
  assign w_idx       = w_addrValid ? WADDR : '0;
  assign w_cur       = r_regs[w_idx];

  // One extra bit: carry out of the sum flags overflow, borrow out of the
  // difference flags underflow.
  assign w_sum  = {1'b0, w_cur} + (WIDTH+1)'(STEP);
  assign w_diff = {1'b0, w_cur} - (WIDTH+1)'(STEP);

  always_comb begin
    w_next   = w_cur;
    w_write  = 1'b0;
    w_setOvf = 1'b0;
    if (w_addrValid && !CLR_ALL) begin
      if (CLR) begin
        w_next  = RESET_VAL;
        w_write = 1'b1;
      end else if (LOAD) begin
        w_next  = inpData;
        w_write = 1'b1;
      end else if (INC) begin
        w_write  = 1'b1;
        w_setOvf = w_sum[WIDTH];
        w_next   = (w_sum[WIDTH] && SAT_MODE != 0) ? '1 : w_sum[WIDTH-1:0];
      end else if (DEC) begin
        w_write  = 1'b1;
        w_setOvf = w_diff[WIDTH];
        w_next   = (w_diff[WIDTH] && SAT_MODE != 0) ? '0 : w_diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      r_ovf <= 1'b0;
    end else begin
      if (CLR_ALL) begin
        for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      end else if (w_write) begin
        r_regs[w_idx] <= w_next;
      end
      // A new overflow outranks a simultaneous clear request.
      if (w_setOvf)     r_ovf <= 1'b1;
      else if (OVF_CLR) r_ovf <= 1'b0;
    end
  end

  assign opDataA = (int'(RADDR_A) < NUM_REGS) ? r_regs[RADDR_A] : '0;
  assign opDataB = (int'(RADDR_B) < NUM_REGS) ? r_regs[RADDR_B] : '0;
  assign ZERO_A  = (opDataA == '0);
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_user_register_bank.sv
// Scoreboard bench for user_register_bank: three instances (wrap, saturate
// with STEP=4, three registers) share one stimulus bus.
module tb_user_register_bank;

  localparam logic [5:0] OP_NONE   = 6'b000000;
  localparam logic [5:0] OP_CLRALL = 6'b100000;
  localparam logic [5:0] OP_CLR    = 6'b010000;
  localparam logic [5:0] OP_LOAD   = 6'b001000;
  localparam logic [5:0] OP_INC    = 6'b000100;
  localparam logic [5:0] OP_DEC    = 6'b000010;
  localparam logic [5:0] OP_OVFCLR = 6'b000001;

  typedef struct {
    int          inst;
    string       name;
    logic [11:0] a;
    logic [11:0] b;
    logic        z;
    logic        o;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   failures = 0;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  WADDR = '0;
  logic [11:0] inpData = '0;
  logic        LOAD = 1'b0, INC = 1'b0, DEC = 1'b0, CLR = 1'b0, CLR_ALL = 1'b0, OVF_CLR = 1'b0;
  logic [1:0]  RADDR_A = '0, RADDR_B = '0;

  logic [11:0] a0, b0, a1, b1, a2, b2;
  logic        z0, o0, z1, o1, z2, o2;

  always #5 CLK = ~CLK;

  user_register_bank dutWrap (
    .CLK(CLK), .RST_N(RST_N), .WADDR(WADDR), .inpData(inpData),
    .LOAD(LOAD), .INC(INC), .DEC(DEC), .CLR(CLR), .CLR_ALL(CLR_ALL), .OVF_CLR(OVF_CLR),
    .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
    .opDataA(a0), .opDataB(b0), .ZERO_A(z0), .OVF(o0));

  user_register_bank #(.STEP(4), .SAT_MODE(1)) dutSat (
    .CLK(CLK), .RST_N(RST_N), .WADDR(WADDR), .inpData(inpData),
    .LOAD(LOAD), .INC(INC), .DEC(DEC), .CLR(CLR), .CLR_ALL(CLR_ALL), .OVF_CLR(OVF_CLR),
    .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
    .opDataA(a1), .opDataB(b1), .ZERO_A(z1), .OVF(o1));

  user_register_bank #(.NUM_REGS(3)) dutThree (
    .CLK(CLK), .RST_N(RST_N), .WADDR(WADDR), .inpData(inpData),
    .LOAD(LOAD), .INC(INC), .DEC(DEC), .CLR(CLR), .CLR_ALL(CLR_ALL), .OVF_CLR(OVF_CLR),
    .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
    .opDataA(a2), .opDataB(b2), .ZERO_A(z2), .OVF(o2));

  // Monitor: registers settle on the falling edge, so every pending
  // expectation is compared on the following rising edge.
  always @(posedge CLK) begin
    while (expQ.size() > 0) begin
      exp_t        e;
      logic [11:0] actA, actB;
      logic        actZ, actO;
      e = expQ.pop_front();
      case (e.inst)
        0:       begin actA = a0; actB = b0; actZ = z0; actO = o0; end
        1:       begin actA = a1; actB = b1; actZ = z1; actO = o1; end
        default: begin actA = a2; actB = b2; actZ = z2; actO = o2; end
      endcase
      testsRun++;
      if (actA !== e.a || actB !== e.b || actZ !== e.z || actO !== e.o) begin
        failures++;
        $display("[TB] FAIL %s: got A=%h B=%h Z=%b OVF=%b, expected A=%h B=%h Z=%b OVF=%b",
                 e.name, actA, actB, actZ, actO, e.a, e.b, e.z, e.o);
      end
    end
  end

  // Drives one operation for the falling edge, then deasserts it.
  task automatic applyStimulus(input logic [5:0] ops, input logic [1:0] waddr,
                               input logic [11:0] data, input logic [1:0] ra,
                               input logic [1:0] rb);
    @(posedge CLK);
    #1;
    {CLR_ALL, CLR, LOAD, INC, DEC, OVF_CLR} = ops;
    WADDR   = waddr;
    inpData = data;
    RADDR_A = ra;
    RADDR_B = rb;
    @(negedge CLK);
    #1;
    {CLR_ALL, CLR, LOAD, INC, DEC, OVF_CLR} = OP_NONE;
  endtask

  task automatic checkOutput(input int inst, input string name, input logic [11:0] a,
                             input logic [11:0] b, input logic z, input logic o);
    exp_t e;
    e.inst = inst; e.name = name; e.a = a; e.b = b; e.z = z; e.o = o;
    expQ.push_back(e);
  endtask

  task automatic resetDuts();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    checkOutput(0, "reset_state", 12'h000, 12'h000, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Wrap-mode bank
    applyStimulus(OP_LOAD, 2'd2, 12'hABC, 2'd2, 2'd0); checkOutput(0, "load_r2", 12'hABC, 12'h000, 1'b0, 1'b0);
    applyStimulus(OP_LOAD, 2'd1, 12'hFFF, 2'd1, 2'd0); checkOutput(0, "load_r1_max", 12'hFFF, 12'h000, 1'b0, 1'b0);
    applyStimulus(OP_INC, 2'd1, 12'h000, 2'd1, 2'd0); checkOutput(0, "inc_wrap", 12'h000, 12'h000, 1'b1, 1'b1);
    applyStimulus(OP_DEC, 2'd1, 12'h000, 2'd1, 2'd0); checkOutput(0, "dec_wrap_ovf_sticky", 12'hFFF, 12'h000, 1'b0, 1'b1);
    applyStimulus(OP_OVFCLR, 2'd1, 12'h000, 2'd1, 2'd0); checkOutput(0, "ovf_clr", 12'hFFF, 12'h000, 1'b0, 1'b0);
    applyStimulus(OP_LOAD, 2'd3, 12'h777, 2'd3, 2'd2); checkOutput(0, "load_r3", 12'h777, 12'hABC, 1'b0, 1'b0);
    applyStimulus(OP_CLR | OP_LOAD | OP_INC, 2'd3, 12'h456, 2'd3, 2'd2); checkOutput(0, "prio_clr", 12'h000, 12'hABC, 1'b1, 1'b0);
    applyStimulus(OP_LOAD | OP_INC, 2'd3, 12'h123, 2'd3, 2'd2); checkOutput(0, "prio_load", 12'h123, 12'hABC, 1'b0, 1'b0);
    applyStimulus(OP_INC | OP_DEC, 2'd3, 12'h000, 2'd3, 2'd2); checkOutput(0, "prio_inc", 12'h124, 12'hABC, 1'b0, 1'b0);
    applyStimulus(OP_LOAD, 2'd3, 12'hFFF, 2'd3, 2'd2); checkOutput(0, "load_r3_max", 12'hFFF, 12'hABC, 1'b0, 1'b0);
    applyStimulus(OP_INC | OP_OVFCLR, 2'd3, 12'h000, 2'd3, 2'd2); checkOutput(0, "ovf_set_beats_clr", 12'h000, 12'hABC, 1'b1, 1'b1);
    applyStimulus(OP_CLR, 2'd2, 12'h000, 2'd2, 2'd1); checkOutput(0, "clr_r2", 12'h000, 12'hFFF, 1'b1, 1'b1);
    applyStimulus(OP_DEC, 2'd0, 12'h000, 2'd0, 2'd3); checkOutput(0, "dec_underflow_wrap", 12'hFFF, 12'h000, 1'b0, 1'b1);
    resetDuts();

    // Saturating bank, STEP=4
    applyStimulus(OP_LOAD, 2'd0, 12'hFFE, 2'd0, 2'd1); checkOutput(1, "sat_load", 12'hFFE, 12'h000, 1'b0, 1'b0);
    applyStimulus(OP_INC, 2'd0, 12'h000, 2'd0, 2'd1); checkOutput(1, "sat_inc_max", 12'hFFF, 12'h000, 1'b0, 1'b1);
    applyStimulus(OP_OVFCLR, 2'd0, 12'h000, 2'd0, 2'd1); checkOutput(1, "sat_ovf_clr", 12'hFFF, 12'h000, 1'b0, 1'b0);
    applyStimulus(OP_INC, 2'd0, 12'h000, 2'd0, 2'd1); checkOutput(1, "sat_inc_again", 12'hFFF, 12'h000, 1'b0, 1'b1);
    applyStimulus(OP_LOAD, 2'd0, 12'h002, 2'd0, 2'd1); checkOutput(1, "sat_load_2", 12'h002, 12'h000, 1'b0, 1'b1);
    applyStimulus(OP_DEC, 2'd0, 12'h000, 2'd0, 2'd1); checkOutput(1, "sat_dec_floor", 12'h000, 12'h000, 1'b1, 1'b1);
    applyStimulus(OP_OVFCLR, 2'd0, 12'h000, 2'd0, 2'd1); checkOutput(1, "sat_ovf_clr2", 12'h000, 12'h000, 1'b1, 1'b0);
    applyStimulus(OP_LOAD, 2'd0, 12'h008, 2'd0, 2'd1); checkOutput(1, "sat_load_8", 12'h008, 12'h000, 1'b0, 1'b0);
    applyStimulus(OP_DEC, 2'd0, 12'h000, 2'd0, 2'd1); checkOutput(1, "sat_dec_step", 12'h004, 12'h000, 1'b0, 1'b0);
    applyStimulus(OP_INC | OP_DEC, 2'd0, 12'h000, 2'd0, 2'd1); checkOutput(1, "sat_inc_step", 12'h008, 12'h000, 1'b0, 1'b0);
    resetDuts();

    // Three-register bank: out-of-range addresses
    applyStimulus(OP_LOAD, 2'd2, 12'h222, 2'd0, 2'd2); checkOutput(2, "n3_load_r2", 12'h000, 12'h222, 1'b1, 1'b0);
    applyStimulus(OP_LOAD, 2'd3, 12'h555, 2'd3, 2'd2); checkOutput(2, "n3_load_oob", 12'h000, 12'h222, 1'b1, 1'b0);
    applyStimulus(OP_LOAD, 2'd0, 12'hFFF, 2'd0, 2'd2); checkOutput(2, "n3_load_r0", 12'hFFF, 12'h222, 1'b0, 1'b0);
    applyStimulus(OP_INC, 2'd3, 12'h000, 2'd0, 2'd2); checkOutput(2, "n3_inc_oob", 12'hFFF, 12'h222, 1'b0, 1'b0);
    applyStimulus(OP_INC, 2'd0, 12'h000, 2'd0, 2'd2); checkOutput(2, "n3_inc_ovf", 12'h000, 12'h222, 1'b1, 1'b1);
    applyStimulus(OP_LOAD, 2'd1, 12'h010, 2'd1, 2'd2); checkOutput(2, "n3_load_r1", 12'h010, 12'h222, 1'b0, 1'b1);
    applyStimulus(OP_CLRALL, 2'd1, 12'h000, 2'd1, 2'd2); checkOutput(2, "n3_clr_all", 12'h000, 12'h000, 1'b1, 1'b1);
    resetDuts();

    // Asynchronous reset between edges with an op pending
    applyStimulus(OP_LOAD, 2'd1, 12'h3C3, 2'd1, 2'd1); checkOutput(0, "rst_pre_load", 12'h3C3, 12'h3C3, 1'b0, 1'b0);
    applyStimulus(OP_LOAD, 2'd1, 12'hFFF, 2'd1, 2'd1); checkOutput(0, "rst_pre_max", 12'hFFF, 12'hFFF, 1'b0, 1'b0);
    applyStimulus(OP_INC, 2'd1, 12'h000, 2'd1, 2'd1); checkOutput(0, "rst_pre_ovf", 12'h000, 12'h000, 1'b1, 1'b1);
    applyStimulus(OP_LOAD, 2'd2, 12'h5A5, 2'd2, 2'd2); checkOutput(0, "rst_pre_r2", 12'h5A5, 12'h5A5, 1'b0, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    INC   = 1'b1;
    WADDR = 2'd2;
    RST_N = 1'b0;
    checkOutput(0, "async_reset", 12'h000, 12'h000, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    RST_N   = 1'b1;
    INC     = 1'b0;
    LOAD    = 1'b1;
    inpData = 12'h0A5;
    @(negedge CLK);
    #1;
    LOAD = 1'b0;
    checkOutput(0, "resume_after_reset", 12'h0A5, 12'h0A5, 1'b0, 1'b0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge CLK);
    if (expQ.size() > 0) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
